// File: rtl/dbg_pkg.sv
//==============================================================================
// Module   : dbg_pkg
// Purpose  : Command bytes, frame sync byte and controller state encoding.
// Revision : 1.0
//==============================================================================
`default_nettype none

package dbg_pkg;

    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_RUN   = 8'h63;
    localparam logic [7:0] CMD_HALT  = 8'h68;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4
    } dbg_state_e;

endpackage

`default_nettype wire

// File: rtl/debug_stream_unit_if.sv
//==============================================================================
// Module   : debug_stream_unit_if
// Purpose  : UART byte handshake, snapshot bus and pipeline controls.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface debug_stream_unit_if #(
    parameter int NUM_WORDS = 40,
    parameter int WORD_W    = 32
);
    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic [NUM_WORDS*WORD_W-1:0] snap_data;
    logic [31:0]                 instr_id;
    logic [7:0]                  tx_data;
    logic                        tx_start;
    logic                        tx_done;
    logic                        enable;
    logic                        enable_pc;
    logic                        busy;
    logic                        halted;

    modport master (
        input  rx_data, rx_valid, snap_data, instr_id, tx_done,
        output tx_data, tx_start, enable, enable_pc, busy, halted
    );

    modport slave (
        output rx_data, rx_valid, snap_data, instr_id, tx_done,
        input  tx_data, tx_start, enable, enable_pc, busy, halted
    );
endinterface

`default_nettype wire

// File: rtl/dbg_frame_tx.sv
//==============================================================================
// Module   : dbg_frame_tx
// Purpose  : Serialises sync, count, snapshot bytes and optional checksum
//            (DBG_CHECKSUM_EN) through a start/done byte handshake.
// Revision : 1.0
//==============================================================================
`default_nettype none

module dbg_frame_tx
    import dbg_pkg::*;
#(
    parameter int NUM_WORDS = 40,
    parameter int WORD_W    = 32
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        go,
    input  wire logic [NUM_WORDS*WORD_W-1:0] snap_data,
    input  wire logic                        tx_done,
    output logic      [7:0]                  tx_data,
    output logic                             tx_start,
    output logic                             busy,
    output logic                             done
);

    localparam int c_num_bytes = NUM_WORDS * WORD_W / 8;
`ifdef DBG_CHECKSUM_EN
    localparam int c_frame_len = c_num_bytes + 3;
`else
    localparam int c_frame_len = c_num_bytes + 2;
`endif
    localparam int c_idx_w = $clog2(c_num_bytes + 3);

    localparam logic [c_idx_w-1:0] c_last_idx      = c_idx_w'(c_frame_len - 1);
    localparam logic [c_idx_w-1:0] c_last_data_idx = c_idx_w'(c_num_bytes + 1);
    localparam logic [c_idx_w-1:0] c_count_idx     = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_one           = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_two           = c_idx_w'(2);

    // ST_HALT doubles as the serialiser's idle state
    localparam logic [2:0] c_st_idle = ST_HALT;
    localparam logic [2:0] c_st_send = ST_SEND;
    localparam logic [2:0] c_st_wait = ST_WAIT;

    logic [2:0]                  r_state;
    logic [c_idx_w-1:0]          r_idx;
    logic [7:0]                  r_tx_data;
    logic [c_idx_w-1:0]          w_idx_nxt;
    logic [c_idx_w-1:0]          w_data_k;
    logic [NUM_WORDS*WORD_W-1:0] w_shifted;
    logic [7:0]                  w_byte_nxt;
    logic [7:0]                  w_csum_nxt;

    assign w_idx_nxt = r_idx + c_one;
    assign w_data_k  = w_idx_nxt - c_two;
    // Flattened snapshot byte k is word k/(W/8), byte k%(W/8), LSB first
    assign w_shifted = snap_data >> {w_data_k, 3'b000};

`ifdef DBG_CHECKSUM_EN
    logic [7:0] r_csum;

    // Sync byte (index 0) stays out of the checksum
    assign w_csum_nxt = (r_idx == '0) ? r_csum : (r_csum ^ r_tx_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= 8'h00;
        end else if (r_state == c_st_idle && go) begin
            r_csum <= 8'h00;
        end else if (r_state == c_st_wait && tx_done) begin
            r_csum <= w_csum_nxt;
        end
    end
`else
    assign w_csum_nxt = 8'h00;
`endif

    always_comb begin
        w_byte_nxt = w_csum_nxt;
        if (w_idx_nxt == c_count_idx) begin
            w_byte_nxt = 8'(NUM_WORDS);
        end else if (w_idx_nxt <= c_last_data_idx) begin
            w_byte_nxt = w_shifted[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            r_tx_data <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (go) begin
                        r_state   <= c_st_send;
                        r_idx     <= '0;
                        r_tx_data <= SYNC_BYTE;
                    end
                end
                c_st_send: r_state <= c_st_wait;
                c_st_wait: begin
                    if (tx_done) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_state   <= c_st_send;
                            r_idx     <= w_idx_nxt;
                            r_tx_data <= w_byte_nxt;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = (r_state == c_st_send);
    assign busy     = (r_state != c_st_idle);
    assign done     = (r_state == c_st_wait) && tx_done && (r_idx == c_last_idx);

endmodule

`default_nettype wire

// File: rtl/debug_stream_unit.sv
//==============================================================================
// Module   : debug_stream_unit
// Purpose  : UART-driven run/step/halt control that dumps a framed snapshot
//            whenever the pipeline stops. Option macro: DBG_CHECKSUM_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module debug_stream_unit
    import dbg_pkg::*;
#(
    parameter int          NUM_WORDS  = 40,
    parameter int          WORD_W     = 32,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input wire logic      clk,
    input wire logic      rst_n,
    debug_stream_unit_if.master dbg
);

    localparam logic [2:0] c_st_halt = ST_HALT;
    localparam logic [2:0] c_st_run  = ST_RUN;
    localparam logic [2:0] c_st_step = ST_STEP;
    localparam logic [2:0] c_st_send = ST_SEND;

    logic [2:0] r_state;
    logic       w_halt_instr;
    logic       w_halt_req;
    logic       w_dump;
    logic       w_go;
    logic       w_frame_done;
    logic       w_enable;

    assign w_halt_instr = (dbg.instr_id == HALT_INSTR);
    assign w_halt_req   = (r_state == c_st_run) &&
                          ((dbg.rx_valid && dbg.rx_data == CMD_HALT) || w_halt_instr);
    assign w_dump       = (r_state == c_st_halt) && dbg.rx_valid && (dbg.rx_data == CMD_DUMP);
    assign w_go         = w_dump || (r_state == c_st_step) || w_halt_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_halt;
        end else begin
            case (r_state)
                c_st_halt: begin
                    if (dbg.rx_valid) begin
                        case (dbg.rx_data)
                            CMD_STEP: r_state <= c_st_step;
                            CMD_RUN:  r_state <= c_st_run;
                            CMD_DUMP: r_state <= c_st_send;
                            default:  r_state <= c_st_halt;
                        endcase
                    end
                end
                c_st_run:  if (w_halt_req) r_state <= c_st_send;
                c_st_step: r_state <= c_st_send;
                c_st_send: if (w_frame_done) r_state <= c_st_halt;
                default:   r_state <= c_st_halt;
            endcase
        end
    end

    // The halt cycle already drops enable so the pipeline freezes before the dump
    assign w_enable      = (r_state == c_st_step) || ((r_state == c_st_run) && !w_halt_req);
    assign dbg.enable    = w_enable;
    assign dbg.enable_pc = w_enable && !w_halt_instr;
    assign dbg.halted    = (r_state == c_st_halt);

    dbg_frame_tx #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) u_frame_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (w_go),
        .snap_data (dbg.snap_data),
        .tx_done   (dbg.tx_done),
        .tx_data   (dbg.tx_data),
        .tx_start  (dbg.tx_start),
        .busy      (dbg.busy),
        .done      (w_frame_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_debug_stream_unit.sv
//==============================================================================
// Module   : tb_debug_stream_unit
// Purpose  : Directed self-checking bench with a frame model and UART model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_debug_stream_unit;
    import dbg_pkg::*;

    localparam int          NW = 2;
    localparam int          WW = 32;
    localparam logic [31:0] HI = 32'hFFFF_FFFF;
`ifdef DBG_CHECKSUM_EN
    localparam int FLEN = NW * WW / 8 + 3;
`else
    localparam int FLEN = NW * WW / 8 + 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_stream_unit_if #(.NUM_WORDS(NW), .WORD_W(WW)) dif ();

    debug_stream_unit #(
        .NUM_WORDS  (NW),
        .WORD_W     (WW),
        .HALT_INSTR (HI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbg   (dif)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    bit         in_flight = 1'b0;
    logic [7:0] held = 8'h00;
    int         done_delay = 2;
    int         ucnt = 0;
    int         en_cnt = 0;
    int         enpc_cnt = 0;
    int         start_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] lit [0:9] = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
                              8'h02, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Frame model: sync, count, bytes LSB-first per word, XOR of count+data
    function automatic void load_frame();
        logic [7:0] b;
        logic [7:0] x;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NW));
        x = 8'(NW);
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < WW / 8; k++) begin
                b = dif.snap_data[w*WW + 8*k +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef DBG_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    // UartTx model: tx_done pulses done_delay cycles after each tx_start
    initial begin
        dif.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            dif.tx_done = 1'b0;
            if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) dif.tx_done = 1'b1;
            end
            if (dif.tx_start) ucnt = done_delay;
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (dif.enable)    en_cnt++;
                if (dif.enable_pc) enpc_cnt++;
                chk("en_while_busy", 32'(dif.enable & dif.busy), 0);
                chk("halted_while_busy", 32'(dif.halted & dif.busy), 0);
                chk("enpc_without_en", 32'(dif.enable_pc & ~dif.enable), 0);
                if (dif.tx_start) begin
                    start_cnt++;
                    chk("start_while_inflight", 32'(in_flight), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx_start: got tx_start data %0h required no start",
                                 dif.tx_data);
                    end else begin
                        chk("tx_byte", 32'(dif.tx_data), 32'(exp_q.pop_front()));
                    end
                    log_q.push_back(dif.tx_data);
                    in_flight = 1'b1;
                    held = dif.tx_data;
                end else if (in_flight) begin
                    chk("tx_data_hold", 32'(dif.tx_data), 32'(held));
                end
                if (dif.tx_done) begin
                    done_cnt++;
                    in_flight = 1'b0;
                end
            end
        end
    end

    task automatic drive_rx(input logic [7:0] b);
        dif.rx_data  = b;
        dif.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1;
        drive_rx(b);
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_frame(input string nm);
        int n = 0;
        while (!(dif.halted && !dif.busy && exp_q.size() == 0 && !in_flight) && n < 2000) begin
            sample();
            n++;
        end
        chk({nm, "_frame_timeout"}, 32'(n < 2000), 1);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_enable"},    32'(dif.enable), 0);
        chk({nm, "_enable_pc"}, 32'(dif.enable_pc), 0);
        chk({nm, "_tx_start"},  32'(dif.tx_start), 0);
        chk({nm, "_tx_data"},   32'(dif.tx_data), 0);
        chk({nm, "_busy"},      32'(dif.busy), 0);
        chk({nm, "_halted"},    32'(dif.halted), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int d0;
        int n;
        dif.rx_data   = 8'h00;
        dif.rx_valid  = 1'b0;
        dif.instr_id  = 32'h0000_0013;
        dif.snap_data = {32'h0000_0002, 32'h1122_3344};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Dump command with the reference snapshot
        load_frame();
        log_q.delete();
        send_cmd(CMD_DUMP);
        sample();
        chk("dump_latency_start", 32'(dif.tx_start), 1);
        chk("dump_busy", 32'(dif.busy), 1);
        wait_frame("dump");
        chk("dump_len", 32'(log_q.size()), 32'(FLEN));
        for (int i = 0; i < 10; i++) chk("dump_literal", 32'(log_q[i]), 32'(lit[i]));
`ifdef DBG_CHECKSUM_EN
        chk("dump_checksum", 32'(log_q[10]), 32'h44);
`endif
        chk("dump_halted", 32'(dif.halted), 1);

        // Single step
        dif.snap_data = {32'hDEAD_BEEF, 32'h0102_0304};
        load_frame();
        log_q.delete();
        en_cnt = 0;
        send_cmd(CMD_STEP);
        sample();
        chk("step_enable", 32'(dif.enable), 1);
        chk("step_enable_pc", 32'(dif.enable_pc), 1);
        chk("step_no_early_start", 32'(dif.tx_start), 0);
        sample();
        chk("step_enable_off", 32'(dif.enable), 0);
        chk("step_start", 32'(dif.tx_start), 1);
        wait_frame("step");
        chk("step_enable_cycles", 32'(en_cnt), 1);
        chk("step_halted", 32'(dif.halted), 1);

        // Run until halt instruction appears after 5 cycles
        dif.snap_data = {32'h8000_0001, 32'hCAFE_F00D};
        load_frame();
        log_q.delete();
        en_cnt = 0;
        enpc_cnt = 0;
        send_cmd(CMD_RUN);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        dif.instr_id = HI;
        sample();
        chk("run_halt_enable", 32'(dif.enable), 0);
        chk("run_halt_enable_pc", 32'(dif.enable_pc), 0);
        chk("run_halt_no_start", 32'(dif.tx_start), 0);
        sample();
        chk("run_halt_start", 32'(dif.tx_start), 1);
        wait_frame("run_halt");
        chk("run_enable_cycles", 32'(en_cnt), 5);
        chk("run_enable_pc_cycles", 32'(enpc_cnt), 5);
        dif.instr_id = 32'h0000_0013;

        // Run then 'h'; commands during the frame are dropped
        dif.snap_data = {32'h5A5A_0F0F, 32'h00FF_7E81};
        load_frame();
        log_q.delete();
        en_cnt = 0;
        send_cmd(CMD_RUN);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        dif.rx_data  = CMD_HALT;
        dif.rx_valid = 1'b1;
        sample();
        chk("h_cycle_enable", 32'(dif.enable), 0);
        @(posedge clk);
        #1;
        dif.rx_valid = 1'b0;
        sample();
        chk("h_start", 32'(dif.tx_start), 1);
        send_cmd(CMD_STEP);
        send_cmd(CMD_RUN);
        wait_frame("h");
        chk("h_enable_cycles", 32'(en_cnt), 2);
        chk("h_halted", 32'(dif.halted), 1);

        // Unknown byte and 'h' in HALT are ignored
        en_cnt = 0;
        s0 = start_cnt;
        send_cmd(8'h78);
        send_cmd(CMD_HALT);
        repeat (5) sample();
        chk("junk_halted", 32'(dif.halted), 1);
        chk("junk_enable_cycles", 32'(en_cnt), 0);
        chk("junk_no_start", 32'(start_cnt), 32'(s0));

        // Slow UART: data must hold for 100-cycle waits
        done_delay = 100;
        dif.snap_data = {32'h1357_9BDF, 32'h2468_ACE0};
        load_frame();
        log_q.delete();
        s0 = start_cnt;
        send_cmd(CMD_DUMP);
        wait_frame("slow");
        chk("slow_start_count", 32'(start_cnt - s0), 32'(FLEN));
        done_delay = 2;

        // Reset after byte 3 completes
        load_frame();
        log_q.delete();
        d0 = done_cnt;
        send_cmd(CMD_DUMP);
        n = 0;
        while (done_cnt - d0 < 3 && n < 200) begin
            sample();
            n++;
        end
        chk("rst_wait_timeout", 32'(n < 200), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        in_flight = 1'b0;
        chk_reset("midrst");
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (10) sample();
        chk("midrst_no_start", 32'(start_cnt), 32'(s0));
        chk("midrst_halted", 32'(dif.halted), 1);
        log_q.delete();
        load_frame();
        send_cmd(CMD_DUMP);
        wait_frame("fresh");
        chk("fresh_first_sync", 32'(log_q[0]), 32'hA5);
        chk("fresh_len", 32'(log_q.size()), 32'(FLEN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
